// File: rtl/shadow_stack_monitor.sv
// ============================================================================
// Module  : shadow_stack_monitor
// Purpose : Hardware shadow stack for mor1kx retiring calls/returns; flags
//           return-address mismatch, underflow and overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shadow_stack_monitor #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = 4,
  parameter int RET_OFFSET = 8,
  parameter int OVF_MODE   = 0,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  insn_valid_i,
  input  logic [31:0]           insn_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [ADDR_WIDTH-1:0] target_i,
  input  logic                  viol_clear_i,
  output logic                  stack_violation,
  output logic                  interrupt,
  output logic [1:0]            cause_o,
  output logic [2:0]            fsm_state,
  output logic [PTR_WIDTH:0]    depth_o,
  output logic [CNT_WIDTH-1:0]  viol_count_o
);

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    RUN      = 3'd1,
    VIOL     = 3'd2
  } state_t;

  localparam logic [PTR_WIDTH:0] FULL           = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [1:0]         CAUSE_MISMATCH = 2'b01;
  localparam logic [1:0]         CAUSE_UNDER    = 2'b10;
  localparam logic [1:0]         CAUSE_OVER     = 2'b11;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   stack [DEPTH];
  logic [PTR_WIDTH-1:0]    wp;
  logic [PTR_WIDTH:0]      count;
  logic [ADDR_WIDTH-1:0]   top;
  logic [ADDR_WIDTH-1:0]   push_addr;
  logic                    is_call, is_ret, is_full, is_empty;
  logic                    do_push, do_pop, viol;
  logic [1:0]              viol_cause;
  logic                    unused_insn_bits;

  assign unused_insn_bits = ^{insn_i[25:16], insn_i[10:0]};

  assign top       = stack[wp - 1'b1];
  assign push_addr = address_i + ADDR_WIDTH'(RET_OFFSET);
  assign is_full   = (count == FULL);
  assign is_empty  = (count == '0);

  // Decode is only live in RUN; VIOL and DISABLED ignore the retire stream.
  assign is_call = insn_valid_i && (state == RUN) &&
                   ((insn_i[31:26] == 6'h01) || (insn_i[31:26] == 6'h12));
  assign is_ret  = insn_valid_i && (state == RUN) &&
                   (insn_i[31:26] == 6'h11) && (insn_i[15:11] == 5'd9);

  always_comb begin
    viol       = 1'b0;
    viol_cause = 2'b00;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    if (is_ret) begin
      if (is_empty) begin
        viol       = 1'b1;
        viol_cause = CAUSE_UNDER;
      end else begin
        do_pop = 1'b1;
        if (top != target_i) begin
          viol       = 1'b1;
          viol_cause = CAUSE_MISMATCH;
        end
      end
    end else if (is_call) begin
      if (is_full && (OVF_MODE == 0)) begin
        viol       = 1'b1;
        viol_cause = CAUSE_OVER;
      end else begin
        do_push = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = DISABLED;
    case (state)
      DISABLED: state_nxt = enable_i ? RUN : DISABLED;
      RUN: begin
        if (viol)           state_nxt = VIOL;
        else if (!enable_i) state_nxt = DISABLED;
        else                state_nxt = RUN;
      end
      VIOL: begin
        if (viol_clear_i) state_nxt = enable_i ? RUN : DISABLED;
        else              state_nxt = VIOL;
      end
      default: state_nxt = DISABLED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= DISABLED;
      wp              <= '0;
      count           <= '0;
      stack_violation <= 1'b0;
      interrupt       <= 1'b0;
      cause_o         <= 2'b00;
      viol_count_o    <= '0;
    end else begin
      state     <= state_nxt;
      interrupt <= viol;
      if (viol) begin
        stack_violation <= 1'b1;
        cause_o         <= viol_cause;
        if (viol_count_o != '1) viol_count_o <= viol_count_o + 1'b1;
      end else if ((state == VIOL) && viol_clear_i) begin
        stack_violation <= 1'b0;
        cause_o         <= 2'b00;
      end
      // In circular mode a full push advances wp but the count saturates.
      if (do_push) begin
        wp <= wp + 1'b1;
        if (!is_full) count <= count + 1'b1;
      end else if (do_pop) begin
        wp    <= wp - 1'b1;
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) stack[wp] <= push_addr;
  end

  assign fsm_state = state;
  assign depth_o   = count;

endmodule

`default_nettype wire

// File: tb/tb_shadow_stack_monitor.sv
// ============================================================================
// Module  : tb_shadow_stack_monitor
// Purpose : Directed vector table plus corner sequences for shadow_stack_monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shadow_stack_monitor;

  localparam logic [31:0] CALL = {6'h01, 26'd0};
  localparam logic [31:0] JALR = {6'h12, 26'd0};
  localparam logic [31:0] RET  = {6'h11, 10'd0, 5'd9, 11'd0};
  localparam logic [31:0] JR3  = {6'h11, 10'd0, 5'd3, 11'd0};
  localparam logic [31:0] NOP  = 32'h1500_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        valid = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] insn = NOP;
  logic [31:0] addr = '0;
  logic [31:0] tgt = '0;

  logic       v0, i0, v1, i1;
  logic [1:0] c0, c1;
  logic [2:0] s0, s1;
  logic [4:0] d0, d1;
  logic [7:0] n0, n1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shadow_stack_monitor #(.OVF_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .enable_i(enable), .insn_valid_i(valid),
    .insn_i(insn), .address_i(addr), .target_i(tgt), .viol_clear_i(clr),
    .stack_violation(v0), .interrupt(i0), .cause_o(c0), .fsm_state(s0),
    .depth_o(d0), .viol_count_o(n0)
  );

  shadow_stack_monitor #(.OVF_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .enable_i(enable), .insn_valid_i(valid),
    .insn_i(insn), .address_i(addr), .target_i(tgt), .viol_clear_i(clr),
    .stack_violation(v1), .interrupt(i1), .cause_o(c1), .fsm_state(s1),
    .depth_o(d1), .viol_count_o(n1)
  );

  typedef struct {
    logic        rst, en, va;
    logic [31:0] insn, addr, tgt;
    logic        clr;
    logic        ev, ei;
    logic [1:0]  ec;
    logic [2:0]  es;
    logic [4:0]  ed;
    logic [7:0]  en_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic r, logic e, logic va, logic [31:0] i,
                             logic [31:0] a, logic [31:0] t, logic c,
                             logic ev, logic ei, logic [1:0] ec,
                             logic [2:0] es, logic [4:0] ed, logic [7:0] ecn);
    vec_t x;
    x.rst = r; x.en = e; x.va = va; x.insn = i; x.addr = a; x.tgt = t;
    x.clr = c; x.ev = ev; x.ei = ei; x.ec = ec; x.es = es; x.ed = ed;
    x.en_cnt = ecn;
    return x;
  endfunction

  function automatic logic [31:0] pk(logic ev, logic ei, logic [1:0] ec,
                                     logic [2:0] es, logic [4:0] ed,
                                     logic [7:0] cnt);
    return {12'd0, ev, ei, ec, es, ed, cnt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h (viol,intr,cause,state,depth,cnt) expected %05h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic va, input logic [31:0] i, input logic [31:0] a,
                     input logic [31:0] t, input logic c);
    valid = va; insn = i; addr = a; tgt = t; clr = c;
  endtask

  task automatic do_reset();
    put(1'b0, NOP, 32'd0, 32'd0, 1'b0);
    reset = 1'b1; enable = 1'b0;
    tick();
    reset = 1'b0; enable = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst en va insn addr tgt clr | viol intr cause state depth cnt
    vq.push_back(v(1'b1,1'b0,1'b0,NOP ,32'h0  ,32'h0  ,1'b0, 1'b0,1'b0,2'd0,3'd0,5'd0,8'd0));
    vq.push_back(v(1'b0,1'b1,1'b0,NOP ,32'h0  ,32'h0  ,1'b0, 1'b0,1'b0,2'd0,3'd1,5'd0,8'd0));
    vq.push_back(v(1'b0,1'b1,1'b1,CALL,32'h100,32'h0  ,1'b0, 1'b0,1'b0,2'd0,3'd1,5'd1,8'd0));
    vq.push_back(v(1'b0,1'b1,1'b1,RET ,32'h0  ,32'h108,1'b0, 1'b0,1'b0,2'd0,3'd1,5'd0,8'd0));
    vq.push_back(v(1'b0,1'b1,1'b1,JALR,32'h100,32'h0  ,1'b0, 1'b0,1'b0,2'd0,3'd1,5'd1,8'd0));
    vq.push_back(v(1'b0,1'b1,1'b1,RET ,32'h0  ,32'h200,1'b0, 1'b1,1'b1,2'd1,3'd2,5'd0,8'd1));
    vq.push_back(v(1'b0,1'b1,1'b0,NOP ,32'h0  ,32'h0  ,1'b0, 1'b1,1'b0,2'd1,3'd2,5'd0,8'd1));
    vq.push_back(v(1'b0,1'b1,1'b1,RET ,32'h0  ,32'h200,1'b0, 1'b1,1'b0,2'd1,3'd2,5'd0,8'd1));
    vq.push_back(v(1'b0,1'b1,1'b0,NOP ,32'h0  ,32'h0  ,1'b1, 1'b0,1'b0,2'd0,3'd1,5'd0,8'd1));
    vq.push_back(v(1'b0,1'b1,1'b1,RET ,32'h0  ,32'h108,1'b0, 1'b1,1'b1,2'd2,3'd2,5'd0,8'd2));
    vq.push_back(v(1'b0,1'b1,1'b1,RET ,32'h0  ,32'h108,1'b1, 1'b0,1'b0,2'd0,3'd1,5'd0,8'd2));
    vq.push_back(v(1'b0,1'b1,1'b1,JR3 ,32'h0  ,32'h55 ,1'b0, 1'b0,1'b0,2'd0,3'd1,5'd0,8'd2));
    vq.push_back(v(1'b0,1'b1,1'b1,CALL,32'h300,32'h0  ,1'b0, 1'b0,1'b0,2'd0,3'd1,5'd1,8'd2));
    vq.push_back(v(1'b0,1'b1,1'b1,NOP ,32'h0  ,32'h0  ,1'b0, 1'b0,1'b0,2'd0,3'd1,5'd1,8'd2));
    vq.push_back(v(1'b0,1'b0,1'b0,NOP ,32'h0  ,32'h0  ,1'b0, 1'b0,1'b0,2'd0,3'd0,5'd1,8'd2));
    vq.push_back(v(1'b0,1'b0,1'b1,CALL,32'h400,32'h0  ,1'b0, 1'b0,1'b0,2'd0,3'd0,5'd1,8'd2));
    vq.push_back(v(1'b0,1'b1,1'b0,NOP ,32'h0  ,32'h0  ,1'b0, 1'b0,1'b0,2'd0,3'd1,5'd1,8'd2));
    vq.push_back(v(1'b0,1'b0,1'b1,RET ,32'h0  ,32'h999,1'b0, 1'b1,1'b1,2'd1,3'd2,5'd0,8'd3));
    vq.push_back(v(1'b0,1'b0,1'b0,NOP ,32'h0  ,32'h0  ,1'b1, 1'b0,1'b0,2'd0,3'd0,5'd0,8'd3));
    vq.push_back(v(1'b0,1'b1,1'b0,NOP ,32'h0  ,32'h0  ,1'b0, 1'b0,1'b0,2'd0,3'd1,5'd0,8'd3));
    for (int k = 0; k < 6; k++)
      vq.push_back(v(1'b0,1'b1,1'b1,CALL,32'(16*(k+1)),32'h0,1'b0,
                     1'b0,1'b0,2'd0,3'd1,5'(k+1),8'd3));
    vq.push_back(v(1'b0,1'b1,1'b1,RET ,32'h0  ,32'h0  ,1'b0, 1'b1,1'b1,2'd1,3'd2,5'd5,8'd4));

    foreach (vq[k]) begin
      reset = vq[k].rst; enable = vq[k].en;
      put(vq[k].va, vq[k].insn, vq[k].addr, vq[k].tgt, vq[k].clr);
      tick();
      chk($sformatf("vec%0d", k), pk(v0, i0, c0, s0, d0, n0),
          pk(vq[k].ev, vq[k].ei, vq[k].ec, vq[k].es, vq[k].ed, vq[k].en_cnt));
    end

    // Asynchronous reset from VIOL with depth 5 and interrupt still high.
    put(1'b0, NOP, 32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_reset", pk(v0, i0, c0, s0, d0, n0), pk(1'b0,1'b0,2'd0,3'd0,5'd0,8'd0));
    tick();
    reset = 1'b0; enable = 1'b1;
    tick();

    // Overflow with drop policy; circular instance must not flag the same calls.
    for (int i = 0; i < 16; i++) begin
      put(1'b1, CALL, 32'h1000 + 32'(4*i), 32'd0, 1'b0);
      tick();
    end
    chk("ovf0_fill", pk(v0, i0, c0, s0, d0, n0), pk(1'b0,1'b0,2'd0,3'd1,5'd16,8'd0));
    put(1'b1, CALL, 32'h1040, 32'd0, 1'b0);
    tick();
    chk("ovf0_cause", pk(v0, i0, c0, s0, d0, n0), pk(1'b1,1'b1,2'd3,3'd2,5'd16,8'd1));
    chk("ovf1_noviol", pk(v1, i1, c1, s1, d1, n1), pk(1'b0,1'b0,2'd0,3'd1,5'd16,8'd0));
    put(1'b0, NOP, 32'd0, 32'd0, 1'b1);
    tick();
    chk("ovf0_clear", pk(v0, i0, c0, s0, d0, n0), pk(1'b0,1'b0,2'd0,3'd1,5'd16,8'd1));
    put(1'b1, RET, 32'd0, 32'h1044, 1'b0);
    tick();
    chk("ovf0_top", pk(v0, i0, c0, s0, d0, n0), pk(1'b0,1'b0,2'd0,3'd1,5'd15,8'd1));

    // Circular policy: 17 calls, 16 matching returns, then underflow.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      put(1'b1, CALL, 32'h2000 + 32'(4*i), 32'd0, 1'b0);
      tick();
    end
    for (int i = 16; i >= 1; i--) begin
      put(1'b1, RET, 32'd0, 32'h2008 + 32'(4*i), 1'b0);
      tick();
    end
    chk("ovf1_unwind", pk(v1, i1, c1, s1, d1, n1), pk(1'b0,1'b0,2'd0,3'd1,5'd0,8'd0));
    put(1'b1, RET, 32'd0, 32'h2008, 1'b0);
    tick();
    chk("ovf1_under", pk(v1, i1, c1, s1, d1, n1), pk(1'b1,1'b1,2'd2,3'd2,5'd0,8'd1));

    // Counter saturation across 300 underflows.
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      put(1'b1, RET, 32'd0, 32'd0, 1'b0);
      tick();
      put(1'b0, NOP, 32'd0, 32'd0, 1'b1);
      tick();
      if (k == 254)
        chk("cnt_254", pk(v0, i0, c0, s0, d0, n0), pk(1'b0,1'b0,2'd0,3'd1,5'd0,8'd254));
    end
    chk("cnt_sat0", pk(v0, i0, c0, s0, d0, n0), pk(1'b0,1'b0,2'd0,3'd1,5'd0,8'd255));
    chk("cnt_sat1", pk(v1, i1, c1, s1, d1, n1), pk(1'b0,1'b0,2'd0,3'd1,5'd0,8'd255));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
